// File: rtl/mutex_client_pkg.sv
// Shared types and constants for the Avalon-MM hardware mutex client.
// The slave's mutex word is {owner[31:16], value[15:0]}; value 0 means free.
package mutex_client_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_LOCK,
    RD_CHECK,
    BACKOFF,
    HELD,
    WR_REL
  } state_t;

  localparam logic        MUTEX_ADDR_VALUE = 1'b0;
  localparam logic        MUTEX_ADDR_RESET = 1'b1;
  localparam logic [15:0] MUTEX_FREE_VALUE = 16'h0000;

  function automatic logic [31:0] mutex_word(input logic [15:0] owner, input logic [15:0] value);
    return {owner, value};
  endfunction

endpackage

// File: rtl/mutex_backoff_timer.sv
// Loadable down-counter that parks at zero; done is high whenever it is zero.
module mutex_backoff_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              count <= '0;
    else if (load)             count <= load_val;
    else if (count != '0)      count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/mutex_client.sv
// Acquires/releases a shared hardware mutex over Avalon-MM on behalf of local logic.
// Write {owner,value}, read back to confirm ownership, back off and retry on contention.
module mutex_client
  import mutex_client_pkg::*;
#(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int          MAX_RETRIES    = 8,
  parameter int          BACKOFF_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acq_req,
  input  logic        rel_req,
  output logic        granted,
  output logic        busy,
  output logic        acq_err,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int             BW           = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [31:0]    LOCK_WORD    = mutex_word(OWNER_ID, LOCK_VALUE);
  localparam logic [31:0]    REL_WORD     = mutex_word(OWNER_ID, MUTEX_FREE_VALUE);
  localparam logic [BW-1:0]  BACKOFF_LOAD = BW'(BACKOFF_CYCLES - 1);
  localparam logic [7:0]     RETRY_LIMIT  = 8'(MAX_RETRIES);

  state_t      state, next_state;
  logic [7:0]  retries;
  logic        backoff_done, check_fail, out_of_retries;
  logic        nxt_write, nxt_read, nxt_busy, nxt_err;
  logic [31:0] nxt_wdata;

  assign check_fail     = (state == RD_CHECK) && !avm_waitrequest && (avm_readdata != LOCK_WORD);
  assign out_of_retries = (retries + 8'd1) == RETRY_LIMIT;
  assign avm_address    = MUTEX_ADDR_VALUE;

  mutex_backoff_timer #(.W(BW)) u_backoff (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (check_fail && !out_of_retries),
    .load_val (BACKOFF_LOAD),
    .done     (backoff_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (acq_req) next_state = WR_LOCK;
      WR_LOCK:  if (!avm_waitrequest) next_state = RD_CHECK;
      RD_CHECK: if (!avm_waitrequest) begin
                  if (avm_readdata == LOCK_WORD) next_state = HELD;
                  else if (out_of_retries)       next_state = IDLE;
                  else                           next_state = BACKOFF;
                end
      BACKOFF:  if (backoff_done) next_state = WR_LOCK;
      HELD:     if (rel_req) next_state = WR_REL;
      WR_REL:   if (!avm_waitrequest) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             retries <= '0;
    else if (state == IDLE && acq_req)        retries <= '0;
    else if (check_fail)                      retries <= retries + 8'd1;
  end

  // Strobes are decoded from next_state so they appear with the state and hold through waitrequest.
  always_comb begin
    nxt_write = (next_state == WR_LOCK) || (next_state == WR_REL);
    nxt_read  = (next_state == RD_CHECK);
    nxt_busy  = (next_state != IDLE) && (next_state != HELD);
    nxt_err   = check_fail && out_of_retries;
    nxt_wdata = '0;
    if (next_state == WR_LOCK)     nxt_wdata = LOCK_WORD;
    else if (next_state == WR_REL) nxt_wdata = REL_WORD;
  end

  // granted follows the state register, so it trails HELD entry and exit by one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      granted        <= 1'b0;
      busy           <= 1'b0;
      acq_err        <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      granted        <= (state == HELD);
      busy           <= nxt_busy;
      acq_err        <= nxt_err;
      avm_chipselect <= nxt_write || nxt_read;
      avm_read       <= nxt_read;
      avm_write      <= nxt_write;
      avm_writedata  <= nxt_wdata;
    end
  end

endmodule

// File: tb/tb_mutex_client.sv
// Directed bench for mutex_client: scripted mutex slave, thread-style reference model, per-cycle compare.
module tb_mutex_client;

  localparam logic [15:0] OWN    = 16'h0001;
  localparam logic [15:0] VAL    = 16'h0001;
  localparam int          MAXR   = 3;
  localparam int          BO     = 4;
  localparam logic [31:0] LOCK_W  = 32'h0001_0001;
  localparam logic [31:0] REL_W   = 32'h0001_0000;
  localparam logic [31:0] OTHER_W = 32'h0002_0005;

  logic        clk = 1'b0, reset_n = 1'b1, acq_req = 1'b0, rel_req = 1'b0;
  logic        granted, busy, acq_err, avm_address, avm_chipselect, avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  mutex_client #(
    .OWNER_ID(OWN), .LOCK_VALUE(VAL), .MAX_RETRIES(MAXR), .BACKOFF_CYCLES(BO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .acq_req(acq_req), .rel_req(rel_req),
    .granted(granted), .busy(busy), .acq_err(acq_err),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: stalls each access wait_n cycles; answers reads with OTHER_W while fail_req is ahead.
  int          wait_n = 0, pend = 0, fail_req = 0, fail_done = 0;
  logic [31:0] mword = '0;
  always @(negedge clk) begin
    if (reset_n && (avm_write || avm_read)) begin
      if (pend < wait_n) begin
        avm_waitrequest = 1'b1; pend++;
      end else begin
        avm_waitrequest = 1'b0; pend = 0;
        if (avm_write) begin
          if (mword[15:0] == 16'h0 || mword[31:16] == avm_writedata[31:16]) mword = avm_writedata;
        end else if (fail_done < fail_req) begin
          avm_readdata = OTHER_W; fail_done++;
        end else avm_readdata = mword;
      end
    end else begin
      avm_waitrequest = 1'b0; pend = 0;
    end
  end

  // Bus monitor
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, idle_cnt = 0;
  logic [31:0] last_wd = '0;
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      if (avm_write && !avm_waitrequest) begin wr_cnt++; last_wd = avm_writedata; end
      if (avm_read && !avm_waitrequest) rd_cnt++;
      if (acq_err) err_cnt++;
      if (busy && !avm_write && !avm_read) idle_cnt++;
    end
  end

  // Reference model: one thread walking the transaction; a reset bump aborts it.
  int   rst_cnt = 0, m_seen = 0;
  logic e_wr = 0, e_rd = 0, e_gr = 0, e_busy = 0, e_err = 0;
  logic [31:0] e_wd = '0;
  bit   held = 0;
  always @(negedge reset_n) rst_cnt++;

  task automatic edge_(output bit ab);
    @(posedge clk);
    ab = (rst_cnt != m_seen) || !reset_n;
  endtask

  task automatic m_access(output bit ab);
    do edge_(ab); while (!ab && avm_waitrequest);
  endtask

  task automatic m_acquire();
    bit ab;
    int tries = 0;
    forever begin
      e_busy = 1; e_wr = 1; e_wd = LOCK_W;
      m_access(ab); if (ab) return;
      e_wr = 0; e_rd = 1;
      m_access(ab); if (ab) return;
      e_rd = 0;
      if (avm_readdata == LOCK_W) begin e_busy = 0; held = 1; return; end
      tries++;
      if (tries == MAXR) begin e_busy = 0; e_err = 1; return; end
      repeat (BO) begin edge_(ab); if (ab) return; end
    end
  endtask

  task automatic m_release();
    bit ab;
    held = 0; e_busy = 1; e_wr = 1; e_wd = REL_W;
    edge_(ab); if (ab) return;
    e_gr = 0;
    while (avm_waitrequest) begin edge_(ab); if (ab) return; end
    e_wr = 0; e_busy = 0;
  endtask

  initial forever begin
    @(posedge clk);
    m_seen = rst_cnt;
    if (!reset_n) begin
      held = 0; e_wr = 0; e_rd = 0; e_gr = 0; e_busy = 0; e_err = 0;
      continue;
    end
    e_err = 0; e_gr = held;
    if (!held && acq_req)     m_acquire();
    else if (held && rel_req) m_release();
  end

  // Per-cycle compare; a reset not yet seen by the model forces an all-zero expectation.
  bit started = 0;
  always @(negedge clk) if (started) begin
    bit z;
    z = (rst_cnt != m_seen) || !reset_n;
    chk("granted",    granted,        z ? 1'b0 : e_gr);
    chk("busy",       busy,           z ? 1'b0 : e_busy);
    chk("acq_err",    acq_err,        z ? 1'b0 : e_err);
    chk("avm_write",  avm_write,      z ? 1'b0 : e_wr);
    chk("avm_read",   avm_read,       z ? 1'b0 : e_rd);
    chk("chipselect", avm_chipselect, z ? 1'b0 : (e_wr | e_rd));
    chk("address",    avm_address,    1'b0);
    if (!z && e_wr) chk("writedata", avm_writedata, e_wd);
  end

  task automatic pulse(input bit a, input bit r, output int n0);
    @(negedge clk); acq_req = a; rel_req = r; n0 = cyc + 1;
    @(negedge clk); acq_req = 0; rel_req = 0;
  endtask

  task automatic wait_granted(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (granted) begin at = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk(name, busy, 1'b0);
  endtask

  initial begin
    int n0, at, b_wr, b_rd, b_err, b_idle;
    #1 reset_n = 1'b0;
    #1 started = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {granted, busy, acq_err, avm_write, avm_read, avm_chipselect}, 6'b0);
    chk("reset_wdata", avm_writedata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Uncontended acquire
    pulse(1, 0, n0);
    chk("t1_write", avm_write, 1'b1);
    chk("t1_wdata", avm_writedata, 32'h0001_0001);
    @(negedge clk);
    chk("t1_read", avm_read, 1'b1);
    wait_granted(20, at);
    chk("t1_grant_cycle", at, n0 + 3);

    // acq_req while held: no bus traffic
    b_wr = wr_cnt; b_rd = rd_cnt;
    pulse(1, 0, n0);
    repeat (4) @(negedge clk);
    chk("t2_no_bus", (wr_cnt - b_wr) + (rd_cnt - b_rd), 0);
    chk("t2_still_granted", granted, 1'b1);

    // Release
    b_wr = wr_cnt;
    pulse(0, 1, n0);
    chk("t3_write", avm_write, 1'b1);
    chk("t3_granted_until_next_edge", granted, 1'b1);
    @(negedge clk);
    chk("t3_granted_fell", granted, 1'b0);
    wait_idle("t3_idle", 20);
    chk("t3_rel_word", last_wd, 32'h0001_0000);
    chk("t3_one_write", wr_cnt - b_wr, 1);

    // rel_req in IDLE: ignored
    b_wr = wr_cnt; b_rd = rd_cnt;
    pulse(0, 1, n0);
    repeat (4) @(negedge clk);
    chk("t4_no_bus", (wr_cnt - b_wr) + (rd_cnt - b_rd), 0);

    // Contention: two foreign readbacks then success
    b_wr = wr_cnt; b_rd = rd_cnt; b_idle = idle_cnt;
    fail_req += 2;
    pulse(1, 0, n0);
    wait_granted(100, at);
    chk("t5_grant_cycle", at, n0 + 15);
    chk("t5_writes", wr_cnt - b_wr, 3);
    chk("t5_reads", rd_cnt - b_rd, 3);
    chk("t5_backoff_idle", idle_cnt - b_idle, 8);
    pulse(0, 1, n0);
    wait_idle("t5_rel_idle", 20);

    // Exhaustion, with an acq_req dropped mid-transaction
    b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt;
    fail_req += 3;
    pulse(1, 0, n0);
    repeat (3) @(negedge clk);
    pulse(1, 0, at);
    wait_idle("t6_idle", 100);
    repeat (3) @(negedge clk);
    chk("t6_writes", wr_cnt - b_wr, 3);
    chk("t6_reads", rd_cnt - b_rd, 3);
    chk("t6_err_pulses", err_cnt - b_err, 1);
    chk("t6_not_granted", granted, 1'b0);

    // Five waitrequest cycles per access
    wait_n = 5;
    pulse(1, 0, n0);
    wait_granted(100, at);
    chk("t7_grant_cycle", at, n0 + 13);
    pulse(0, 1, n0);
    wait_idle("t7_rel_idle", 50);
    chk("t7_rel_word", last_wd, REL_W);
    wait_n = 0;

    // acq_req and rel_req together in IDLE: acquire wins
    pulse(1, 1, n0);
    chk("t8_acq_wins", {avm_write, avm_writedata}, {1'b1, LOCK_W});
    wait_granted(20, at);
    chk("t8_grant_cycle", at, n0 + 3);
    pulse(0, 1, n0);
    wait_idle("t8_rel_idle", 20);

    // Reset during backoff, then a clean acquire
    fail_req += 1;
    pulse(1, 0, n0);
    repeat (3) @(negedge clk);
    chk("t9_in_backoff", {busy, avm_write, avm_read}, 3'b100);
    @(posedge clk); #2 reset_n = 1'b0;
    #1 chk("t9_reset_zero", {granted, busy, acq_err, avm_write, avm_read, avm_chipselect}, 6'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    pulse(1, 0, n0);
    wait_granted(20, at);
    chk("t9_grant_cycle", at, n0 + 3);
    pulse(0, 1, n0);
    wait_idle("t9_rel_idle", 20);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
